// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// The optional parity output is enabled with the USR_PARITY_EN macro.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101,
    CLR  = 3'b110,
    RSVD = 3'b111
  } usr_mode_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Port bundle for universal_shift_reg; parity only exists when USR_PARITY_EN is defined.
// master drives set/mode/data/serial inputs; slave (the register) drives Q, serial outputs and counter status.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  import usr_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  logic             set;
  usr_mode_e        mode;
  logic [WIDTH-1:0] data;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             drained;
  logic [CW-1:0]    shift_cnt;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  modport master (
    output set, mode, data, ser_in_r, ser_in_l,
    input  Q, Q_bar, ser_out_l, ser_out_r, drained, shift_cnt
`ifdef USR_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  set, mode, data, ser_in_r, ser_in_l,
    output Q, Q_bar, ser_out_l, ser_out_r, drained, shift_cnt
`ifdef USR_PARITY_EN
    , output parity
`endif
  );

endinterface

// File: rtl/usr_shift_counter.sv
// Saturating shift counter: preset-to-max beats clear beats increment; drained flags max.
module usr_shift_counter #(
  parameter int MAX = 8,
  parameter int CW  = usr_pkg::cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          preset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          drained
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

  always_ff @(posedge clk) begin
    if (preset) begin
      cnt <= CNT_MAX;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign drained = (cnt == CNT_MAX);

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (load/shift/rotate/clear) with a shifts-since-load counter.
// Define USR_PARITY_EN to add a registered parity output tracking ^Q.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  universal_shift_reg_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             is_shift;
  logic             cnt_preset;
  logic             cnt_clear;
  logic [CW-1:0]    cnt;
  logic             drained;

  // q_next folds in reset/set so the parity register can follow Q exactly.
  always_comb begin
    q_next   = q;
    is_shift = 1'b0;
    if (reset) begin
      q_next = RESET_VALUE;
    end else if (bus.set) begin
      q_next = SET_VALUE;
    end else begin
      case (bus.mode)
        LOAD: q_next = bus.data;
        SHL: begin
          q_next   = {q[WIDTH-2:0], bus.ser_in_r};
          is_shift = 1'b1;
        end
        SHR: begin
          q_next   = {bus.ser_in_l, q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        ROL: begin
          q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
          is_shift = 1'b1;
        end
        ROR: begin
          q_next   = {q[0], q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        CLR:     q_next = '0;
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    q <= q_next;
  end

  assign cnt_preset = reset || (!bus.set && (bus.mode == CLR));
  assign cnt_clear  = bus.set || (bus.mode == LOAD);

  usr_shift_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_cnt (
    .clk     (clk),
    .preset  (cnt_preset),
    .clear   (cnt_clear),
    .inc     (is_shift),
    .cnt     (cnt),
    .drained (drained)
  );

`ifdef USR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    parity_q <= ^q_next;
  end

  assign bus.parity = parity_q;
`endif

  assign bus.Q         = q;
  assign bus.Q_bar     = ~q;
  assign bus.ser_out_l = q[WIDTH-1];
  assign bus.ser_out_r = q[0];
  assign bus.shift_cnt = cnt;
  assign bus.drained   = drained;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8 (parity checks with USR_PARITY_EN).
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs after an edge, then sample #1 after the next edge
  task automatic step(input logic rst, input logic st, input usr_mode_e m,
                      input logic [WIDTH-1:0] d, input logic sr, input logic sl);
    reset        = rst;
    bus.set      = st;
    bus.mode     = m;
    bus.data     = d;
    bus.ser_in_r = sr;
    bus.ser_in_l = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input usr_mode_e m, input logic [WIDTH-1:0] d, input logic sr, input logic sl);
    step(1'b0, 1'b0, m, d, sr, sl);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, LOAD, 8'hA5, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h exp=00", bus.Q); end
    n_cmp++; if (bus.Q_bar !== 8'hFF) begin n_err++; $display("FAIL reset_qbar got=%h exp=FF", bus.Q_bar); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL reset_drained got=%b exp=1", bus.drained); end
    n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL reset_cnt got=%0d exp=8", bus.shift_cnt); end
  endtask

  task automatic test_serialise();
    logic [WIDTH-1:0] seq;
    seq = 8'hB4;
    op(LOAD, 8'hB4, 1'b0, 1'b0);
    n_cmp++; if (bus.Q !== 8'hB4) begin n_err++; $display("FAIL ser_load_q got=%h exp=B4", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL ser_load_cnt got=%0d exp=0", bus.shift_cnt); end
    n_cmp++; if (bus.ser_out_l !== 1'b1) begin n_err++; $display("FAIL ser_out_l got=%b exp=1", bus.ser_out_l); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.ser_out_r !== seq[i]) begin
        n_err++; $display("FAIL ser_bit%0d got=%b exp=%b", i, bus.ser_out_r, seq[i]);
      end
      op(SHR, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (bus.shift_cnt !== 4'(i + 1)) begin
        n_err++; $display("FAIL ser_cnt%0d got=%0d exp=%0d", i, bus.shift_cnt, i + 1);
      end
      n_cmp++;
      if (bus.drained !== (i == 7)) begin
        n_err++; $display("FAIL ser_drained%0d got=%b exp=%b", i, bus.drained, (i == 7));
      end
      n_cmp++;
      if (bus.Q !== (seq >> (i + 1))) begin
        n_err++; $display("FAIL ser_q%0d got=%h exp=%h", i, bus.Q, seq >> (i + 1));
      end
    end
  endtask

  task automatic test_rotate();
    op(LOAD, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) op(ROL, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h81) begin n_err++; $display("FAIL rol8_q got=%h exp=81", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL rol8_cnt got=%0d exp=8", bus.shift_cnt); end
    op(ROL, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h03) begin n_err++; $display("FAIL rol9_q got=%h exp=03", bus.Q); end
    op(ROL, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h06) begin n_err++; $display("FAIL rol10_q got=%h exp=06", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL rol10_cnt got=%0d exp=8", bus.shift_cnt); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL rol10_drained got=%b exp=1", bus.drained); end
  endtask

  task automatic test_ror_shr_shl();
    op(LOAD, 8'h01, 1'b0, 1'b0);
    op(ROR, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (bus.Q !== 8'h80) begin n_err++; $display("FAIL ror_q got=%h exp=80", bus.Q); end
    op(SHR, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (bus.Q !== 8'hC0) begin n_err++; $display("FAIL shr1_q got=%h exp=C0", bus.Q); end
    op(SHL, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (bus.Q !== 8'h81) begin n_err++; $display("FAIL shl1_q got=%h exp=81", bus.Q); end
    n_cmp++; if (bus.Q_bar !== 8'h7E) begin n_err++; $display("FAIL shl1_qbar got=%h exp=7E", bus.Q_bar); end
    n_cmp++; if (bus.shift_cnt !== 4'd3) begin n_err++; $display("FAIL shl1_cnt got=%0d exp=3", bus.shift_cnt); end
  endtask

  task automatic test_set_vs_mode();
    op(LOAD, 8'h3C, 1'b0, 1'b0);
    n_cmp++; if (bus.Q !== 8'h3C) begin n_err++; $display("FAIL set_pre_q got=%h exp=3C", bus.Q); end
    step(1'b0, 1'b1, CLR, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (bus.Q !== 8'hFF) begin n_err++; $display("FAIL set_q got=%h exp=FF", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL set_cnt got=%0d exp=0", bus.shift_cnt); end
    n_cmp++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL set_drained got=%b exp=0", bus.drained); end
    op(CLR, 8'hFF, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL clr_q got=%h exp=00", bus.Q); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL clr_drained got=%b exp=1", bus.drained); end
  endtask

  task automatic test_deserialise_rsvd();
    logic [7:0] bits;
    bits = 8'b1100_1010;  // bits[7] enters first
    op(CLR, 8'h00, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) op(SHL, 8'h00, bits[i], 1'b0);
    n_cmp++; if (bus.Q !== 8'hCA) begin n_err++; $display("FAIL deser_q got=%h exp=CA", bus.Q); end
    for (int i = 0; i < 3; i++) begin
      op(RSVD, 8'h55, 1'(i), 1'(~i));
      n_cmp++; if (bus.Q !== 8'hCA) begin n_err++; $display("FAIL rsvd_q%0d got=%h exp=CA", i, bus.Q); end
      n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL rsvd_cnt%0d got=%0d exp=8", i, bus.shift_cnt); end
    end
  endtask

  task automatic test_hold_and_abort();
    op(LOAD, 8'h5A, 1'b0, 1'b0);
    op(SHL, 8'h00, 1'b0, 1'b0);
    op(HOLD, 8'hFF, 1'b1, 1'b1);
    op(HOLD, 8'hFF, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'hB4) begin n_err++; $display("FAIL hold_q got=%h exp=B4", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd1) begin n_err++; $display("FAIL hold_cnt got=%0d exp=1", bus.shift_cnt); end
    step(1'b1, 1'b0, SHL, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL abort_q got=%h exp=00", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL abort_cnt got=%0d exp=8", bus.shift_cnt); end
    op(LOAD, 8'h0F, 1'b0, 1'b0);
    op(SHR, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (bus.shift_cnt !== 4'd1) begin n_err++; $display("FAIL restart_cnt got=%0d exp=1", bus.shift_cnt); end
    n_cmp++; if (bus.Q !== 8'h07) begin n_err++; $display("FAIL restart_q got=%h exp=07", bus.Q); end
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    op(LOAD, 8'h07, 1'b0, 1'b0);
    n_cmp++; if (bus.parity !== 1'b1) begin n_err++; $display("FAIL par_load07 got=%b exp=1", bus.parity); end
    op(SHL, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (bus.Q !== 8'h0E) begin n_err++; $display("FAIL par_shl_q got=%h exp=0E", bus.Q); end
    n_cmp++; if (bus.parity !== 1'b1) begin n_err++; $display("FAIL par_shl got=%b exp=1", bus.parity); end
    op(LOAD, 8'h03, 1'b0, 1'b0);
    n_cmp++; if (bus.parity !== 1'b0) begin n_err++; $display("FAIL par_load03 got=%b exp=0", bus.parity); end
    op(SHL, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (bus.parity !== 1'b1) begin n_err++; $display("FAIL par_shl07 got=%b exp=1", bus.parity); end
    step(1'b1, 1'b0, SHL, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (bus.parity !== 1'b0) begin n_err++; $display("FAIL par_reset got=%b exp=0", bus.parity); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    step(1'b1, 1'b0, HOLD, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, HOLD, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_serialise();
    test_rotate();
    test_ror_shr_shl();
    test_set_vs_mode();
    test_deserialise_rsvd();
    test_hold_and_abort();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised WIDTH-bit register with synchronous reset and set, parallel load, shift, rotate and clear modes.
- Tracks the number of shifts since the last load, so it can serve as a serialiser or deserialiser front-end.
- Successor to the team's 1-bit D flip-flop; same priority order (reset > set > data path), generalised in width and mode.
- Sits between datapath registers and serial links or bit-serial engines.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value of Q after reset.
- SET_VALUE, {WIDTH{1'b1}}, value of Q after set.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; highest priority.
- set  input  1  synchronous, active-high; second priority.
- mode  input  3  operation select (encodings under Behaviour).
- data  input  WIDTH  parallel load value.
- ser_in_r  input  1  bit entering the LSB on shift-left.
- ser_in_l  input  1  bit entering the MSB on shift-right.
- Q  output  WIDTH  registered value.
- Q_bar  output  WIDTH  ~Q, combinational.
- ser_out_l  output  1  Q[WIDTH-1], combinational from the register.
- ser_out_r  output  1  Q[0], combinational from the register.
- drained  output  1  high when shift count equals WIDTH.
- shift_cnt  output  $clog2(WIDTH+1)  shifts since the last load, saturating.

Behaviour:
- Clock and reset: single clock domain. All state updates on posedge clk. No asynchronous paths.
- Priority per cycle:
  - reset=1: Q<=RESET_VALUE, shift_cnt<=WIDTH (drained=1).
  - else set=1: Q<=SET_VALUE, shift_cnt<=0.
  - else decode mode.
- Mode encodings:
  - 3'b000 HOLD: Q and shift_cnt unchanged.
  - 3'b001 LOAD: Q<=data, shift_cnt<=0.
  - 3'b010 SHL: Q<={Q[WIDTH-2:0],ser_in_r}; shift_cnt increments.
  - 3'b011 SHR: Q<={ser_in_l,Q[WIDTH-1:1]}; shift_cnt increments.
  - 3'b100 ROL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; shift_cnt increments.
  - 3'b101 ROR: Q<={Q[0],Q[WIDTH-1:1]}; shift_cnt increments.
  - 3'b110 CLR: Q<=0, shift_cnt<=WIDTH.
  - 3'b111 reserved: behaves as HOLD; must not corrupt state.
- Counter:
  - Increments saturate at WIDTH; no wrap-around. Further shifts keep shifting Q while shift_cnt stays at WIDTH.
  - drained = (shift_cnt == WIDTH), combinational from the counter.
- Latency: every operation is visible on Q one cycle after the sampling edge. Serial outputs reflect the current Q, so the first bit is available the cycle after LOAD.
- Simultaneous events:
  - reset with set: reset wins.
  - set with any mode: set wins; mode is ignored that cycle.
- Reset mid-sequence: aborts the shift sequence; the next LOAD restarts counting from 0.
- No X propagation: ser_in_* is only sampled in SHL/SHR.

Optional Feature:
- Macro: USR_PARITY_EN.
- With the macro defined:
  - Adds output parity (1 bit), a register updated alongside Q, equal to ^Q_next.
  - Reset and CLR give parity = ^RESET_VALUE and 0 respectively.
  - parity is valid in the same cycle as Q, with no extra latency.
- Without the macro: no parity port and no parity logic; all other behaviour is identical.

Decomposition:
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_mode_e: HOLD, LOAD, SHL, SHR, ROL, ROR, CLR, RSVD.
  - function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One sub-module is natural: usr_shift_counter, a saturating counter with clear/preset-to-max/increment and the drained output. The data register stays in the top level.

Test Plan:
- Reset priority: WIDTH=8; assert reset and set together with mode=LOAD, data=8'hA5 -> next cycle Q=8'h00, Q_bar=8'hFF, drained=1, shift_cnt=8.
- Load then serialise: LOAD 8'hB4, then 8 cycles of SHR with ser_in_l=0 -> ser_out_r sequence 0,0,1,0,1,1,0,1; shift_cnt steps 1..8; drained rises on the 8th shift; Q=8'h00.
- Rotate with saturation: LOAD 8'h81, then 10×ROL -> Q returns to 8'h81 after 8 shifts and equals 8'h06 after 10; shift_cnt holds at 8.
- Set vs mode: Q=8'h3C; set=1 with mode=CLR -> Q=8'hFF, shift_cnt=0. Next cycle mode=CLR -> Q=0, drained=1.
- Deserialise plus reserved mode: CLR, then 8×SHL with ser_in_r bits 1,1,0,0,1,0,1,0 -> Q=8'hCA. Then mode=3'b111 for 3 cycles -> Q stays 8'hCA, shift_cnt stays 8.
- USR_PARITY_EN build: LOAD 8'h07 -> parity=1; SHL with ser_in_r=0 -> Q=8'h0E, parity=1; LOAD 8'h03 -> parity=0; reset mid-shift -> parity=0.
